// File: rtl/tx_frm_sched.sv
// tx_frm_sched: frame scheduler/sequencer for the tx_eth transmit engine.
// Queues per-frame byte-length descriptors, releases a frame once all of its
// QWs are committed in ibuf, offers back-to-back sends via rsk and re-issues
// a frame after a MAC underrun.
// Optional build macro: TX_FRM_SCHED_STATS_EN adds frm_cnt/urun_cnt outputs.
module tx_frm_sched #(
    parameter int BW    = 9,
    parameter int DQ_AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          desc_wr,
    input  logic [15:0]   desc_len,
    output logic          desc_full,
    output logic          desc_err,
    input  logic [BW:0]   committed_prod,
    output logic          trig,
    output logic [12:0]   qw_len,
    output logic [7:0]    lst_ben,
    output logic          rsk,
    input  logic          rsk_tk,
    input  logic          sync,
    input  logic          tx_underrun
`ifdef TX_FRM_SCHED_STATS_EN
    ,
    output logic [31:0]   frm_cnt,
    output logic [15:0]   urun_cnt
`endif
);

    localparam int PW   = BW + 1;
    localparam int DQ_D = 1 << DQ_AW;
    localparam logic [13:0] MAX_QW = 14'(1 << BW);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_TRIG = 2'd2;
    localparam logic [1:0] ST_BUSY = 2'd3;

    // Byte enables of the last QW from the residual byte count.
    function automatic logic [7:0] f_lst_ben(input logic [2:0] rem);
        case (rem)
            3'd0:    f_lst_ben = 8'hFF;
            3'd1:    f_lst_ben = 8'h01;
            3'd2:    f_lst_ben = 8'h03;
            3'd3:    f_lst_ben = 8'h07;
            3'd4:    f_lst_ben = 8'h0F;
            3'd5:    f_lst_ben = 8'h1F;
            3'd6:    f_lst_ben = 8'h3F;
            3'd7:    f_lst_ben = 8'h7F;
            default: f_lst_ben = 8'hFF;
        endcase
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       r_init_cnt;
    logic             r_trig;
    logic             r_rsk;
    logic             r_desc_err;
    logic             r_full;
    logic             r_retry;
    logic             r_reload;
    logic [12:0]      r_qw_len;
    logic [7:0]       r_lst_ben;
    logic [PW-1:0]    r_issue_ptr;
    logic [12:0]      r_mem_qw  [DQ_D];
    logic [7:0]       r_mem_ben [DQ_D];
    logic [DQ_AW-1:0] r_wr_ptr;
    logic [DQ_AW-1:0] r_rd_ptr;
    logic [DQ_AW:0]   r_count;

    logic [DQ_AW:0]   w_count_nxt;
    logic [13:0]      w_push_qw;
    logic             w_push_bad;
    logic             w_push_ok;
    logic             w_push_rej;
    logic [DQ_AW-1:0] w_sec_ptr;
    logic [12:0]      w_head_qw;
    logic [7:0]       w_head_ben;
    logic [12:0]      w_sec_qw;
    logic [PW-1:0]    w_avail;
    logic [PW-1:0]    w_issue_nxt;
    logic [PW-1:0]    w_avail2;
    logic             w_head_elig;
    logic             w_sec_elig;
    logic             w_retry_now;
    logic             w_pop;
    logic             w_b2b;

    // Descriptor decode: QW count rounds up; runts and oversize frames are rejected.
    assign w_push_qw  = 14'(({1'b0, desc_len} + 17'd7) >> 3);
    assign w_push_bad = (desc_len < 16'd64) || (w_push_qw > MAX_QW);
    assign w_push_ok  = desc_wr & ~r_full & ~w_push_bad;
    assign w_push_rej = desc_wr & ~r_full & w_push_bad;

    // Head / second entry and modulo availability (wrap bit makes avail non-negative).
    assign w_sec_ptr   = r_rd_ptr + DQ_AW'(1);
    assign w_head_qw   = r_mem_qw[r_rd_ptr];
    assign w_head_ben  = r_mem_ben[r_rd_ptr];
    assign w_sec_qw    = r_mem_qw[w_sec_ptr];
    assign w_avail     = committed_prod - r_issue_ptr;
    assign w_issue_nxt = r_issue_ptr + PW'(r_qw_len);
    assign w_avail2    = committed_prod - w_issue_nxt;
    assign w_head_elig = (r_count != '0) && (32'(w_avail) >= 32'(w_head_qw));
    assign w_sec_elig  = (r_count > (DQ_AW+1)'(1)) && (32'(w_avail2) >= 32'(w_sec_qw));

    // A frame end pops the head unless an underrun was seen during the frame.
    assign w_retry_now = r_retry | tx_underrun;
    assign w_pop       = (r_state == ST_BUSY) & ~r_reload & sync & ~w_retry_now;
    assign w_b2b       = w_pop & rsk_tk & (r_count > (DQ_AW+1)'(1));

    // Next FIFO occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop) begin
            w_count_nxt = r_count + (DQ_AW+1)'(1);
        end else if (!w_push_ok && w_pop) begin
            w_count_nxt = r_count - (DQ_AW+1)'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Descriptor storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_qw[r_wr_ptr]  <= w_push_qw[12:0];
            r_mem_ben[r_wr_ptr] <= f_lst_ben(desc_len[2:0]);
        end
    end

    // FIFO pointers, occupancy, full flag and reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_desc_err <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + DQ_AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + DQ_AW'(1);
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == (DQ_AW+1)'(DQ_D));
            r_desc_err <= w_push_rej;
        end
    end

    // Frame sequencing FSM with registered trig/rsk/qw_len/lst_ben.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= 2'd0;
            r_trig      <= 1'b0;
            r_rsk       <= 1'b0;
            r_retry     <= 1'b0;
            r_reload    <= 1'b0;
            r_qw_len    <= 13'd0;
            r_lst_ben   <= 8'd0;
            r_issue_ptr <= '0;
        end else begin
            r_trig <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_rsk <= 1'b0;
                    if (r_init_cnt == 2'd3) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_init_cnt <= r_init_cnt + 2'd1;
                    end
                end
                ST_IDLE: begin
                    r_rsk <= 1'b0;
                    if (w_head_elig) begin
                        r_qw_len  <= w_head_qw;
                        r_lst_ben <= w_head_ben;
                        r_trig    <= 1'b1;
                        r_state   <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (r_reload) begin
                        // Back-to-back: the popped pointer now addresses the next frame.
                        r_qw_len  <= w_head_qw;
                        r_lst_ben <= w_head_ben;
                        r_reload  <= 1'b0;
                        r_rsk     <= 1'b0;
                        if (tx_underrun) r_retry <= 1'b1;
                    end else if (sync) begin
                        r_rsk <= 1'b0;
                        if (w_retry_now) begin
                            r_retry <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_issue_ptr <= w_issue_nxt;
                            if (w_b2b) begin
                                r_reload <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end else begin
                        if (tx_underrun) r_retry <= 1'b1;
                        // A frame about to be retried must not be followed back-to-back.
                        r_rsk <= w_sec_elig & ~w_retry_now;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

`ifdef TX_FRM_SCHED_STATS_EN
    logic [31:0] r_frm_cnt;
    logic [15:0] r_urun_cnt;

    // Completed-frame and underrun counters, wrapping at maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frm_cnt  <= 32'd0;
            r_urun_cnt <= 16'd0;
        end else begin
            if (w_pop) r_frm_cnt <= r_frm_cnt + 32'd1;
            if ((r_state == ST_BUSY) && tx_underrun) r_urun_cnt <= r_urun_cnt + 16'd1;
        end
    end

    assign frm_cnt  = r_frm_cnt;
    assign urun_cnt = r_urun_cnt;
`endif

    assign desc_full = r_full;
    assign desc_err  = r_desc_err;
    assign trig      = r_trig;
    assign qw_len    = r_qw_len;
    assign lst_ben   = r_lst_ben;
    assign rsk       = r_rsk;

endmodule

// File: tb/tb_tx_frm_sched.sv
// Self-checking bench for tx_frm_sched (default build, BW=9, DQ_AW=4).
// Reference model: descriptor queue of (qw, ben) computed arithmetically
// from the byte length, plus the issue pointer kept modulo 1024.
module tb_tx_frm_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        desc_wr;
    logic [15:0] desc_len;
    logic        desc_full;
    logic        desc_err;
    logic [9:0]  committed_prod;
    logic        trig;
    logic [12:0] qw_len;
    logic [7:0]  lst_ben;
    logic        rsk;
    logic        rsk_tk;
    logic        sync;
    logic        tx_underrun;

    int n_tests = 0;
    int n_fail  = 0;
    int m_issue = 0;
    int q_qw[$];
    int q_ben[$];

    typedef struct {
        int len;
        int err;
        int qw;
        int ben;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    tx_frm_sched dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .desc_wr        (desc_wr),
        .desc_len       (desc_len),
        .desc_full      (desc_full),
        .desc_err       (desc_err),
        .committed_prod (committed_prod),
        .trig           (trig),
        .qw_len         (qw_len),
        .lst_ben        (lst_ben),
        .rsk            (rsk),
        .rsk_tk         (rsk_tk),
        .sync           (sync),
        .tx_underrun    (tx_underrun)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int qw_of(input int len);
        return (len + 7) / 8;
    endfunction

    function automatic int ben_of(input int len);
        int r;
        r = len % 8;
        return (r == 0) ? 255 : ((1 << r) - 1);
    endfunction

    function automatic bit bad_of(input int len);
        return (len < 64) || (qw_of(len) > 512);
    endfunction

    task automatic set_avail(input int k);
        committed_prod = 10'((m_issue + k) % 1024);
    endtask

    task automatic push(input int len);
        bit exp_err;
        exp_err  = (q_qw.size() < 16) && bad_of(len);
        if ((q_qw.size() < 16) && !bad_of(len)) begin
            q_qw.push_back(qw_of(len));
            q_ben.push_back(ben_of(len));
        end
        desc_len = 16'(len);
        desc_wr  = 1'b1;
        tick();
        desc_wr  = 1'b0;
        chk("desc_err", desc_err, int'(exp_err));
        chk("desc_full", desc_full, int'(q_qw.size() == 16));
    endtask

    task automatic wait_trig(input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (trig === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic expect_frame(input string nm);
        int c;
        wait_trig(40, c);
        chk({nm, "_trig"}, int'(c >= 0), 1);
        if (c >= 0 && q_qw.size() > 0) begin
            chk({nm, "_qw_len"}, qw_len, q_qw[0]);
            chk({nm, "_lst_ben"}, lst_ben, q_ben[0]);
        end
    endtask

    task automatic model_pop();
        m_issue = (m_issue + q_qw[0]) % 1024;
        void'(q_qw.pop_front());
        void'(q_ben.pop_front());
    endtask

    // Plain frame end; availability is then closed so nothing fires unasked.
    task automatic end_frame();
        tick();
        tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        model_pop();
        set_avail(0);
    endtask

    task automatic underrun_frame();
        tick();
        tx_underrun = 1'b1;
        tick();
        tx_underrun = 1'b0;
        tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    // Back-to-back take: new qw_len/lst_ben must show two edges after sync.
    task automatic take_b2b(input string nm);
        int ntrig;
        sync   = 1'b1;
        rsk_tk = 1'b1;
        tick();
        sync   = 1'b0;
        rsk_tk = 1'b0;
        model_pop();
        chk({nm, "_rsk_drop"}, rsk, 0);
        tick();
        chk({nm, "_qw_len"}, qw_len, q_qw[0]);
        chk({nm, "_lst_ben"}, lst_ben, q_ben[0]);
        ntrig = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (trig === 1'b1) ntrig++;
        end
        chk({nm, "_no_trig"}, ntrig, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        q_qw.delete();
        q_ben.delete();
        m_issue = 0;
        committed_prod = 10'd0;
        chk("rst_trig", trig, 0);
        chk("rst_rsk", rsk, 0);
        chk("rst_desc_err", desc_err, 0);
        chk("rst_desc_full", desc_full, 0);
        chk("rst_qw_len", qw_len, 0);
        chk("rst_lst_ben", lst_ben, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        int hq;
        int extra;
        int mode;
        int len;
        bit exp_rsk;

        tbl[0]  = '{64,    0, 8,   8'hFF};
        tbl[1]  = '{63,    1, 0,   0};
        tbl[2]  = '{61,    1, 0,   0};
        tbl[3]  = '{69,    0, 9,   8'h1F};
        tbl[4]  = '{100,   0, 13,  8'h0F};
        tbl[5]  = '{4096,  0, 512, 8'hFF};
        tbl[6]  = '{4097,  1, 0,   0};
        tbl[7]  = '{65535, 1, 0,   0};
        tbl[8]  = '{75,    0, 10,  8'h07};
        tbl[9]  = '{130,   0, 17,  8'h03};
        tbl[10] = '{127,   0, 16,  8'h7F};
        tbl[11] = '{1,     1, 0,   0};

        desc_wr = 1'b0; desc_len = 16'd0; committed_prod = 10'd0;
        rsk_tk = 1'b0; sync = 1'b0; tx_underrun = 1'b0;
        tick();
        do_reset();

        // First frame straight out of reset: no trig during the 4-cycle hold-off.
        set_avail(8);
        push(64);
        wait_trig(40, c);
        chk("holdoff_trig_seen", int'(c >= 0), 1);
        chk("holdoff_not_early", int'(c >= 3), 1);
        chk("t1_qw_len", qw_len, 8);
        chk("t1_lst_ben", lst_ben, 8'hFF);
        end_frame();

        // Table: rejects, and for accepted lengths one QW short holds, exact releases.
        for (int i = 0; i < 12; i++) begin
            push(tbl[i].len);
            chk("tbl_err", desc_err, tbl[i].err);
            if (tbl[i].err == 0) begin
                set_avail(tbl[i].qw - 1);
                wait_trig(6, c);
                chk("tbl_hold", c, -1);
                set_avail(tbl[i].qw);
                wait_trig(20, c);
                chk("tbl_trig", int'(c >= 0), 1);
                chk("tbl_qw_len", qw_len, tbl[i].qw);
                chk("tbl_lst_ben", lst_ben, tbl[i].ben);
                tick(); tick(); tick();
                chk("tbl_rsk_single", rsk, 0);
                end_frame();
            end
        end

        // Back-to-back: 64 + 100 with 21 QWs committed.
        push(64);
        push(100);
        set_avail(21);
        expect_frame("b2b1");
        tick(); tick(); tick();
        chk("b2b_rsk", rsk, 1);
        take_b2b("b2b2");
        chk("b2b2_qw13", qw_len, 13);
        chk("b2b2_ben0f", lst_ben, 8'h0F);
        end_frame();

        // Second entry one QW short: rsk stays low; it then runs normally.
        push(64);
        push(100);
        set_avail(20);
        expect_frame("nob2b1");
        tick(); tick(); tick();
        chk("nob2b_rsk", rsk, 0);
        end_frame();
        set_avail(13);
        expect_frame("nob2b2");
        end_frame();

        // Underrun: head retained, re-triggered against an unchanged issue_ptr.
        push(64);
        set_avail(8);
        expect_frame("urun1");
        underrun_frame();
        expect_frame("urun_retry");
        end_frame();

        // Reset mid-frame flushes the FIFO.
        push(64);
        push(64);
        set_avail(16);
        expect_frame("pre_rst");
        tick();
        do_reset();
        committed_prod = 10'd16;
        wait_trig(15, c);
        chk("post_rst_flushed", c, -1);
        committed_prod = 10'd0;

        // Pointer wrap: issue_ptr to 1020, committed_prod wraps to 3 then 4.
        push(4080);
        set_avail(510);
        expect_frame("wrap_a");
        end_frame();
        push(4080);
        set_avail(510);
        expect_frame("wrap_b");
        end_frame();
        chk("wrap_issue_model", m_issue, 1020);
        push(64);
        set_avail(7);
        chk("wrap_cp3", committed_prod, 3);
        wait_trig(8, c);
        chk("wrap_hold", c, -1);
        set_avail(8);
        expect_frame("wrap");
        end_frame();

        // Reject, fill to 16, drop the 17th, then drain exactly 16 frames.
        push(40);
        for (int i = 0; i < 17; i++) push(64);
        chk("full_depth", q_qw.size(), 16);
        for (int i = 0; i < 16; i++) begin
            set_avail(8);
            expect_frame("drain");
            end_frame();
        end
        set_avail(8);
        wait_trig(10, c);
        chk("drain_dropped", c, -1);
        set_avail(0);

        // Randomized traffic against the queue model.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) == 0) len = $urandom_range(1, 63);
            else                           len = $urandom_range(64, 4200);
            push(len);
            if (q_qw.size() > 0 && $urandom_range(0, 1) == 1) begin
                hq    = q_qw[0];
                extra = $urandom_range(0, 1023 - hq);
                set_avail(hq + extra);
                exp_rsk = (q_qw.size() >= 2) && (extra >= q_qw[1]);
                expect_frame("rnd");
                tick(); tick(); tick();
                chk("rnd_rsk", rsk, int'(exp_rsk));
                mode = $urandom_range(0, 2);
                if (mode == 0) begin
                    underrun_frame();
                    expect_frame("rnd_retry");
                    end_frame();
                end else if (mode == 1 && exp_rsk) begin
                    take_b2b("rnd_b2b");
                    end_frame();
                end else begin
                    end_frame();
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
